rx_frame_sync: RTL and testbench

//  Downstream of the K28.5/control-symbol detector in the RX path. Consumes its registered byte stream
//  (rx_DataS) and control flag (rx_Valid = 1 means a control symbol). It achieves symbol lock on COM
//  (0xBC) and tracks loss of lock. While locked, it extracts framed payload (STP/SDP ... END/EDB) into
//  a byte stream with start-of-packet, end-of-packet and abort markers.

---
 rtl/rx_frame_sync_if.sv | 25 ++
 rtl/rx_frame_sync.sv | 247 ++++++++++++++++++++++++
 tb/tb_rx_frame_sync.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_sync_if.sv
// Byte-stream bus between the RX control-symbol detector and the frame
// synchroniser. The master drives the symbol stream; the slave returns the
// de-framed payload and the lock status.
interface rx_frame_sync_if;
  logic       enb;
  logic [7:0] rx_DataS;
  logic       rx_Valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       out_abort;
  logic       locked;
  logic       frame_err;

  modport master (
    output enb, rx_DataS, rx_Valid,
    input  out_data, out_valid, out_sop, out_eop, out_abort, locked, frame_err
  );

  modport slave (
    input  enb, rx_DataS, rx_Valid,
    output out_data, out_valid, out_sop, out_eop, out_abort, locked, frame_err
  );
endinterface

// File: rtl/rx_frame_sync.sv
// RX frame synchroniser: acquires symbol lock on COM, drops lock when COMs
// stop arriving, and while locked extracts STP/SDP..END/EDB framed payload.
// A one-byte hold register delays payload by one data beat so that the byte
// carrying EOP is the real last byte of the frame.
module rx_frame_sync #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter logic [7:0] STP      = 8'hFB,
  parameter logic [7:0] SDP      = 8'h5C,
  parameter logic [7:0] SKP      = 8'h1C,
  parameter logic [7:0] END      = 8'hFD,
  parameter logic [7:0] EDB      = 8'hFE,
  parameter int         LOCK_CNT = 4,
  parameter int         MAX_GAP  = 255,
  parameter int         MAX_LEN  = 1024
) (
  input  logic           clk,
  input  logic           rst,
  rx_frame_sync_if.slave bus
);

  localparam int CW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

  typedef enum logic [1:0] {S_UNLOCKED, S_ALIGN, S_LOCKED} sync_e;
  typedef enum logic [1:0] {F_IDLE, F_FRAME, F_DROP}       frame_e;

  sync_e         sync_q, sync_d;
  frame_e        frm_q, frm_d;
  logic [CW-1:0] com_q, com_d;
  logic [7:0]    gap_q, gap_d;
  logic [10:0]   len_q, len_d;
  logic [7:0]    hold_q, hold_d;
  logic          hv_q, hv_d;
  logic          first_q, first_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          abt_q, abt_d;
  logic          ferr_q, ferr_d;

  logic is_com, is_fill, is_start, is_end, is_edb, is_data;
  logic tmo, lk_beat;

  // Fill symbols (COM/SKP) take precedence over framing codes so they can
  // never open or close a frame, even with unusual parameter choices.
  assign is_com   = bus.rx_Valid && (bus.rx_DataS == COM);
  assign is_fill  = bus.rx_Valid && (bus.rx_DataS == COM || bus.rx_DataS == SKP);
  assign is_start = bus.rx_Valid && !is_fill && (bus.rx_DataS == STP || bus.rx_DataS == SDP);
  assign is_end   = bus.rx_Valid && !is_fill && (bus.rx_DataS == END);
  assign is_edb   = bus.rx_Valid && !is_fill && (bus.rx_DataS == EDB);
  assign is_data  = !bus.rx_Valid;

  // The timeout beat itself is treated as an unlocked beat by the framer.
  assign tmo     = bus.enb && !is_com && (sync_q != S_UNLOCKED) && (gap_q == 8'(MAX_GAP));
  assign lk_beat = bus.enb && (sync_q == S_LOCKED) && !tmo;

  // Sync FSM next state: COM counting toward lock and COM-gap watchdog.
  always_comb begin
    sync_d = sync_q;
    com_d  = com_q;
    gap_d  = gap_q;
    if (bus.enb) begin
      case (sync_q)
        S_UNLOCKED: begin
          if (is_com) begin
            gap_d = '0;
            if (LOCK_CNT <= 1) begin
              sync_d = S_LOCKED;
              com_d  = '0;
            end else begin
              sync_d = S_ALIGN;
              com_d  = CW'(1);
            end
          end
        end
        S_ALIGN: begin
          if (is_com) begin
            gap_d = '0;
            if (com_q + CW'(1) == CW'(LOCK_CNT)) begin
              sync_d = S_LOCKED;
              com_d  = '0;
            end else begin
              com_d = com_q + CW'(1);
            end
          end else if (tmo) begin
            sync_d = S_UNLOCKED;
            com_d  = '0;
            gap_d  = '0;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        S_LOCKED: begin
          if (is_com) begin
            gap_d = '0;
          end else if (tmo) begin
            sync_d = S_UNLOCKED;
            gap_d  = '0;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        default: sync_d = S_UNLOCKED;
      endcase
    end
  end

  // Frame FSM next state and output strobes; H is emitted one data beat late.
  always_comb begin
    frm_d   = frm_q;
    len_d   = len_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    first_d = first_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    abt_d   = 1'b0;
    ferr_d  = 1'b0;
    if (bus.enb) begin
      if (!lk_beat) begin
        // Not locked (or losing lock on this beat): truncate any open frame.
        if (frm_q == F_FRAME && hv_q) begin
          vld_d   = 1'b1;
          data_d  = hold_q;
          sop_d   = first_q;
          eop_d   = 1'b1;
          abt_d   = 1'b1;
          first_d = 1'b0;
        end
        frm_d = F_IDLE;
        hv_d  = 1'b0;
        if (is_start || is_end || is_edb) ferr_d = 1'b1;
      end else begin
        case (frm_q)
          F_IDLE: begin
            if (is_start) begin
              frm_d   = F_FRAME;
              len_d   = '0;
              first_d = 1'b1;
              hv_d    = 1'b0;
            end
          end
          F_FRAME: begin
            if (is_data) begin
              if (len_q >= 11'(MAX_LEN)) begin
                vld_d   = 1'b1;
                data_d  = hold_q;
                sop_d   = first_q;
                eop_d   = 1'b1;
                abt_d   = 1'b1;
                first_d = 1'b0;
                hv_d    = 1'b0;
                frm_d   = F_DROP;
              end else begin
                if (hv_q) begin
                  vld_d   = 1'b1;
                  data_d  = hold_q;
                  sop_d   = first_q;
                  first_d = 1'b0;
                end
                hold_d = bus.rx_DataS;
                hv_d   = 1'b1;
                len_d  = len_q + 11'd1;
              end
            end else if (is_start || is_end || is_edb) begin
              if (hv_q) begin
                vld_d   = 1'b1;
                data_d  = hold_q;
                sop_d   = first_q;
                eop_d   = 1'b1;
                abt_d   = !is_end;
                first_d = 1'b0;
              end else begin
                ferr_d = 1'b1;
              end
              hv_d = 1'b0;
              if (is_start) begin
                frm_d   = F_FRAME;
                len_d   = '0;
                first_d = 1'b1;
              end else begin
                frm_d = F_IDLE;
              end
            end
          end
          F_DROP: begin
            if (is_end || is_edb) begin
              frm_d = F_IDLE;
            end else if (is_start) begin
              frm_d   = F_FRAME;
              len_d   = '0;
              first_d = 1'b1;
              hv_d    = 1'b0;
            end
          end
          default: frm_d = F_IDLE;
        endcase
      end
    end
  end

  // State, counters, hold register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= S_UNLOCKED;
      frm_q   <= F_IDLE;
      com_q   <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      hv_q    <= 1'b0;
      first_q <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      abt_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      frm_q   <= frm_d;
      com_q   <= com_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      first_q <= first_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      abt_q   <= abt_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.out_sop   = sop_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_abort = abt_q;
  assign bus.frame_err = ferr_q;
  assign bus.locked    = (sync_q == S_LOCKED);

endmodule

// File: tb/tb_rx_frame_sync.sv
// Bench for rx_frame_sync: three parameterisations share one stimulus stream
// and each is compared every cycle against a frame-level reference model.
module tb_rx_frame_sync;

  localparam logic [2:0][3:0]  LC = {4'd1,   4'd4,  4'd4};
  localparam logic [2:0][7:0]  MG = {8'd8,   8'd8,  8'd255};
  localparam logic [2:0][10:0] ML = {11'd16, 11'd4, 11'd1024};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dv;
  logic [7:0] din;

  // flags: {valid, sop, eop, abort, locked, frame_err}
  logic [7:0] o_d [3];
  logic [5:0] o_f [3];
  logic [7:0] e_d [3];
  logic [5:0] e_f [3];

  bit         m_lk   [3];
  int         m_coms [3];
  int         m_gap  [3];
  int         m_mode [3];  // 0 outside frame, 1 in frame, 2 dropping
  logic [7:0] mq     [3][$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    rx_frame_sync_if bus ();
    assign bus.enb      = en;
    assign bus.rx_Valid = dv;
    assign bus.rx_DataS = din;
    rx_frame_sync #(
      .LOCK_CNT(int'(LC[g])),
      .MAX_GAP (int'(MG[g])),
      .MAX_LEN (int'(ML[g]))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );
    assign o_d[g] = bus.out_data;
    assign o_f[g] = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_abort,
                     bus.locked, bus.frame_err};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic emit(input int c, input logic [7:0] b, input bit s, input bit e, input bit a);
    e_d[c]      = b;
    e_f[c][5:2] = {1'b1, s, e, a};
  endtask

  task automatic mreset();
    for (int c = 0; c < 3; c++) begin
      m_lk[c] = 0; m_coms[c] = 0; m_gap[c] = 0; m_mode[c] = 0;
      mq[c].delete();
      e_f[c] = '0; e_d[c] = '0;
    end
  endtask

  // Reference: lock = enough COMs without too long a COM-less run; payload
  // is the byte list of the open frame, each byte emitted when its successor
  // (or the frame end) is seen.
  task automatic model(input int c, input logic e, input logic v, input logic [7:0] d);
    bit com, st, fe, fb, was, tmo, lk;
    int n;
    e_f[c] = '0;
    if (e) begin
      com = v && d == 8'hBC;
      st  = v && (d == 8'hFB || d == 8'h5C);
      fe  = v && d == 8'hFD;
      fb  = v && d == 8'hFE;
      was = m_lk[c];
      tmo = 0;
      if (com) begin
        m_gap[c] = 0;
        if (!m_lk[c]) begin
          m_coms[c]++;
          if (m_coms[c] >= int'(LC[c])) begin m_lk[c] = 1; m_coms[c] = 0; end
        end
      end else if (m_lk[c] || m_coms[c] > 0) begin
        if (m_gap[c] == int'(MG[c])) begin
          tmo = 1; m_lk[c] = 0; m_coms[c] = 0; m_gap[c] = 0;
        end else m_gap[c]++;
      end
      lk = was && !tmo;
      n  = mq[c].size();
      if (!lk) begin
        if (m_mode[c] == 1 && n > 0) emit(c, mq[c][n-1], n == 1, 1, 1);
        m_mode[c] = 0;
        mq[c].delete();
        if (st || fe || fb) e_f[c][0] = 1'b1;
      end else if (m_mode[c] == 1) begin
        if (!v) begin
          if (n == int'(ML[c])) begin
            emit(c, mq[c][n-1], n == 1, 1, 1);
            m_mode[c] = 2;
            mq[c].delete();
          end else begin
            mq[c].push_back(d);
            if (n >= 1) emit(c, mq[c][n-1], n == 1, 0, 0);
          end
        end else if (st || fe || fb) begin
          if (n > 0) emit(c, mq[c][n-1], n == 1, 1, !fe);
          else e_f[c][0] = 1'b1;
          mq[c].delete();
          m_mode[c] = st ? 1 : 0;
        end
      end else if (st) begin
        m_mode[c] = 1;
        mq[c].delete();
      end else if (m_mode[c] == 2 && (fe || fb)) begin
        m_mode[c] = 0;
      end
    end
    e_f[c][1] = m_lk[c];
  endtask

  task automatic step(input logic e, input logic v, input logic [7:0] d);
    @(negedge clk);
    en = e; dv = v; din = d;
    for (int c = 0; c < 3; c++) model(c, e, v, d);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("cfg%0d flags", c), 32'(o_f[c]), 32'(e_f[c]));
      if (e_f[c][5]) chk($sformatf("cfg%0d data", c), 32'(o_d[c]), 32'(e_d[c]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++)
      chk($sformatf("cfg%0d reset", c), 32'({o_d[c], o_f[c]}), 32'h0);
    mreset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic coms(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 8'hBC);
  endtask

  task automatic dats(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'($urandom));
  endtask

  initial begin
    int r;
    logic e;
    rst = 1'b0; en = 1'b0; dv = 1'b0; din = '0;
    mreset();
    do_reset();

    // lock acquisition and the gap boundary while aligning
    coms(4);
    do_reset(); coms(3); dats(255); coms(1);
    do_reset(); coms(3); dats(256); coms(1);

    // good frame, nullified frame, empty frame
    do_reset(); coms(4);
    step(1, 1, 8'hFB); step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 1, 8'hFD);
    step(1, 1, 8'hFB); step(1, 0, 8'hAA); step(1, 1, 8'hFE);
    step(1, 1, 8'hFB); step(1, 1, 8'hFD);
    // restart inside a frame, SKP/COM ignored inside frame
    step(1, 1, 8'h5C); step(1, 0, 8'h44); step(1, 1, 8'h1C); step(1, 0, 8'h55);
    step(1, 1, 8'hBC); step(1, 1, 8'hFB); step(1, 0, 8'h66); step(1, 1, 8'hFD);

    // overflow (MAX_LEN=4 instance)
    step(1, 1, 8'hFB);
    for (int i = 1; i <= 6; i++) step(1, 0, 8'(i));
    step(1, 1, 8'hFD);

    // lock loss mid-frame (MAX_GAP=8 instances)
    coms(4);
    step(1, 1, 8'hFB); step(1, 0, 8'h01); step(1, 0, 8'h02); dats(12);
    step(1, 1, 8'hFD);

    // enb gaps inside a frame, then async reset mid-frame
    do_reset(); coms(4);
    step(1, 1, 8'hFB); step(1, 0, 8'h10); step(0, 0, 8'h99); step(0, 1, 8'hFD);
    step(1, 0, 8'h20); step(0, 1, 8'hBC); step(1, 0, 8'h30);
    do_reset();
    step(1, 0, 8'h40); step(1, 1, 8'hFD);

    // randomized traffic
    coms(4);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      e = ($urandom_range(0, 9) != 0);
      if (r < 50)      step(e, 0, 8'($urandom));
      else if (r < 62) step(e, 1, 8'hBC);
      else if (r < 68) step(e, 1, ($urandom_range(0, 1) != 0) ? 8'hFB : 8'h5C);
      else if (r < 74) step(e, 1, ($urandom_range(0, 1) != 0) ? 8'hFD : 8'hFE);
      else if (r < 80) step(e, 1, 8'h1C);
      else if (r < 84) step(e, 1, 8'($urandom));
      else             step(e, 0, 8'($urandom));
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
